// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and pending-vector population count for the register file scoreboard
package regfile_pkg;

  localparam int DEF_XLEN  = 64;
  localparam int DEF_AW    = 5;
  localparam int DEF_NRD   = 2;
  localparam int MAX_NREGS = 1024;
  localparam int CNT_W     = $clog2(MAX_NREGS) + 1;

  // Callers zero-extend their pending vector; the unused upper bits fold away.
  function automatic logic [CNT_W-1:0] popcount(input logic [MAX_NREGS-1:0] vec);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_NREGS; i++) begin
      cnt = cnt + CNT_W'(vec[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// rtl/regfile_rdport.sv - one read port: storage select, x0 mask, write-through mux under REGFILE_BYPASS_EN
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int AW   = DEF_AW
) (
  input  logic [AW-1:0]                 addr,
  input  logic [2**AW-1:0][XLEN-1:0]    regs,
  input  logic [2**AW-1:0]              pend_vec,
  output logic [XLEN-1:0]               data,
  output logic                          pend
`ifdef REGFILE_BYPASS_EN
  ,
  input  logic                          byp_ok,
  input  logic                          wr_en,
  input  logic [AW-1:0]                 wr_addr,
  input  logic [XLEN-1:0]               wr_data,
  input  logic                          iss_en,
  input  logic [AW-1:0]                 iss_rd
`endif
);

`ifdef REGFILE_BYPASS_EN
  logic wr_hit;
  logic iss_hit;
  // byp_ok keeps forwarded data off the port while reset is held.
  assign wr_hit  = byp_ok && wr_en && (wr_addr == addr);
  assign iss_hit = iss_en && (iss_rd == addr);
`endif

  always_comb begin
    data = '0;
    pend = 1'b0;
    if (addr != '0) begin
      data = regs[addr];
      pend = pend_vec[addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_hit) begin
        data = wr_data;
        pend = iss_hit & pend_vec[addr];
      end
`endif
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with pending-write scoreboard; REGFILE_BYPASS_EN enables write-through reads
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int AW   = DEF_AW,
  parameter int NRD  = DEF_NRD
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [XLEN-1:0]      wr_data,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_rd,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_pend,
  output logic [AW:0]          pend_cnt
);

  localparam int NREGS = 2**AW;

  logic [NREGS-1:0][XLEN-1:0] regs;
  logic [NREGS-1:0]           p;
  logic [NREGS-1:0]           p_next;
  logic [AW:0]                pend_cnt_next;

  // Issue is applied after writeback so a same-edge new producer keeps the bit set.
  always_comb begin
    p_next = p;
    if (wr_en && (wr_addr != '0)) p_next[wr_addr] = 1'b0;
    if (iss_en && (iss_rd != '0)) p_next[iss_rd] = 1'b1;
    p_next[0] = 1'b0;
  end

  assign pend_cnt_next = (AW+1)'(popcount(MAX_NREGS'(p_next)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs     <= '0;
      p        <= '0;
      pend_cnt <= '0;
    end else begin
      if (wr_en && (wr_addr != '0)) regs[wr_addr] <= wr_data;
      p        <= p_next;
      pend_cnt <= pend_cnt_next;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rdport
    regfile_rdport #(
      .XLEN (XLEN),
      .AW   (AW)
    ) u_rdport (
      .addr     (rd_addr[k*AW +: AW]),
      .regs     (regs),
      .pend_vec (p),
      .data     (rd_data[k*XLEN +: XLEN]),
      .pend     (rd_pend[k])
`ifdef REGFILE_BYPASS_EN
      ,
      .byp_ok   (rst_n),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .iss_en   (iss_en),
      .iss_rd   (iss_rd)
`endif
    );
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed self-checking bench for regfile_scoreboard
module tb_regfile_scoreboard;

  localparam int XLEN = 64;
  localparam int AW   = 5;
  localparam int NRD  = 2;

  logic                 clk;
  logic                 rst_n;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [XLEN-1:0]      wr_data;
  logic                 iss_en;
  logic [AW-1:0]        iss_rd;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_pend;
  logic [AW:0]          pend_cnt;

  int tests = 0;
  int fails = 0;

  regfile_scoreboard #(.XLEN(XLEN), .AW(AW), .NRD(NRD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_rd   (iss_rd),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_pend  (rd_pend),
    .pend_cnt (pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    iss_en  = 1'b0;
    iss_rd  = '0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic test_reset();
    idle();
    set_rd(5'd5, 5'd5);
    rst_n = 1'b0;
    step();
    tests++;
    if (pend_cnt !== 6'd0) begin fails++; $display("FAIL reset_cnt got %0d exp 0", pend_cnt); end
    rst_n = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEAD;
    step();
    idle();
    iss_en = 1'b1; iss_rd = 5'd5;
    step();
    idle();
    tests++;
    if (rd_data[63:0] !== 64'hDEAD || pend_cnt !== 6'd1) begin
      fails++; $display("FAIL pre_reset got %h/%0d exp dead/1", rd_data[63:0], pend_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (rd_data !== '0 || pend_cnt !== 6'd0 || rd_pend !== 2'b00) begin
      fails++; $display("FAIL reset_clear got %h/%0d/%b exp 0/0/00", rd_data[63:0], pend_cnt, rd_pend);
    end
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hBEEF;
    iss_en = 1'b1; iss_rd = 5'd5;
    step();
    tests++;
    if (rd_data !== '0 || pend_cnt !== 6'd0 || rd_pend !== 2'b00) begin
      fails++; $display("FAIL reset_hold got %h/%0d/%b exp 0/0/00", rd_data[63:0], pend_cnt, rd_pend);
    end
    idle();
    rst_n = 1'b1;
  endtask

  task automatic test_x0();
    set_rd(5'd0, 5'd0);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 64'hFFFF;
    iss_en = 1'b1; iss_rd = 5'd0;
    #1;
    tests++;
    if (rd_data !== '0 || rd_pend !== 2'b00) begin
      fails++; $display("FAIL x0_comb got %h/%b exp 0/00", rd_data[63:0], rd_pend);
    end
    step();
    idle();
    tests++;
    if (rd_data !== '0 || pend_cnt !== 6'd0 || rd_pend !== 2'b00) begin
      fails++; $display("FAIL x0_after got %h/%0d/%b exp 0/0/00", rd_data[63:0], pend_cnt, rd_pend);
    end
  endtask

  task automatic test_scoreboard();
    set_rd(5'd3, 5'd7);
    iss_en = 1'b1; iss_rd = 5'd3;
    step();
    iss_rd = 5'd7;
    step();
    idle();
    tests++;
    if (pend_cnt !== 6'd2 || rd_pend !== 2'b11) begin
      fails++; $display("FAIL sb_issue got %0d/%b exp 2/11", pend_cnt, rd_pend);
    end
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h1234;
    step();
    idle();
    tests++;
    if (pend_cnt !== 6'd1 || rd_pend !== 2'b10 || rd_data[63:0] !== 64'h1234) begin
      fails++; $display("FAIL sb_write got %0d/%b/%h exp 1/10/1234", pend_cnt, rd_pend, rd_data[63:0]);
    end
  endtask

  task automatic test_collision();
    set_rd(5'd9, 5'd7);
    iss_en = 1'b1; iss_rd = 5'd9;
    step();
    tests++;
    if (pend_cnt !== 6'd2 || rd_pend !== 2'b11) begin
      fails++; $display("FAIL col_setup got %0d/%b exp 2/11", pend_cnt, rd_pend);
    end
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'h55;
    #1;
    tests++;
    if (rd_pend[0] !== 1'b1) begin
      fails++; $display("FAIL col_comb_pend got %b exp 1", rd_pend[0]);
    end
    step();
    idle();
    tests++;
    if (pend_cnt !== 6'd2 || rd_pend[0] !== 1'b1 || rd_data[63:0] !== 64'h55) begin
      fails++; $display("FAIL col_after got %0d/%b/%h exp 2/1/55", pend_cnt, rd_pend[0], rd_data[63:0]);
    end
  endtask

  task automatic test_reissue_and_plain_write();
    set_rd(5'd7, 5'd12);
    iss_en = 1'b1; iss_rd = 5'd7;
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 64'h77;
    step();
    idle();
    tests++;
    if (pend_cnt !== 6'd2 || rd_pend !== 2'b01 || rd_data[127:64] !== 64'h77) begin
      fails++; $display("FAIL reissue got %0d/%b/%h exp 2/01/77", pend_cnt, rd_pend, rd_data[127:64]);
    end
  endtask

  task automatic test_bypass();
    set_rd(5'd4, 5'd4);
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 64'h1111;
    step();
    wr_data = 64'hABCD;
    #1;
    tests++;
`ifdef REGFILE_BYPASS_EN
    if (rd_data !== {64'hABCD, 64'hABCD} || rd_pend !== 2'b00) begin
      fails++; $display("FAIL byp_same got %h/%h exp abcd/abcd", rd_data[63:0], rd_data[127:64]);
    end
`else
    if (rd_data !== {64'h1111, 64'h1111} || rd_pend !== 2'b00) begin
      fails++; $display("FAIL byp_same got %h/%h exp 1111/1111", rd_data[63:0], rd_data[127:64]);
    end
`endif
    step();
    idle();
    tests++;
    if (rd_data !== {64'hABCD, 64'hABCD}) begin
      fails++; $display("FAIL byp_next got %h/%h exp abcd/abcd", rd_data[63:0], rd_data[127:64]);
    end
    set_rd(5'd12, 5'd9);
    wr_en = 1'b1; wr_addr = 5'd20; wr_data = 64'h99;
    #1;
    tests++;
    if (rd_data !== {64'h55, 64'h77} || rd_pend !== 2'b10) begin
      fails++; $display("FAIL concurrent got %h/%h/%b exp 77/55/10", rd_data[63:0], rd_data[127:64], rd_pend);
    end
    step();
    idle();
  endtask

  task automatic test_async_reset();
    set_rd(5'd20, 5'd9);
    iss_en = 1'b1; iss_rd = 5'd20;
    step();
    idle();
    tests++;
    if (pend_cnt !== 6'd3) begin fails++; $display("FAIL burst_cnt got %0d exp 3", pend_cnt); end
    iss_en = 1'b1; iss_rd = 5'd21;
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (pend_cnt !== 6'd0 || rd_data !== '0 || rd_pend !== 2'b00) begin
      fails++; $display("FAIL async_rst got %0d/%h/%b exp 0/0/00", pend_cnt, rd_data[63:0], rd_pend);
    end
    idle();
    #1 rst_n = 1'b1;
    iss_en = 1'b1; iss_rd = 5'd6;
    set_rd(5'd6, 5'd21);
    step();
    idle();
    tests++;
    if (pend_cnt !== 6'd1 || rd_pend !== 2'b01) begin
      fails++; $display("FAIL post_rst got %0d/%b exp 1/01", pend_cnt, rd_pend);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    rd_addr = '0;
    test_reset();
    test_x0();
    test_scoreboard();
    test_collision();
    test_reissue_and_plain_write();
    test_bypass();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
